// File: rtl/fixed_point_pkg.sv
// Shared constants and types for the sign-magnitude Q16.16 arithmetic operators.
package fixed_point_pkg;

  localparam int N_DEF = 32;
  localparam int Q_DEF = 16;

  localparam logic [31:0] ONE_Q16   = 32'h0001_0000;
  localparam logic [15:0] LN2_Q16   = 16'hB172;
  localparam logic [31:0] ERR_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_ITER,
    ST_SCALE,
    ST_DONE
  } log_state_e;

endpackage

// File: rtl/fixed_lod.sv
// Combinational leading-one detector: position of the highest set bit plus a zero flag.
module fixed_lod #(
  parameter int W  = 31,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  mag_i,
  output logic [PW-1:0] pos_o,
  output logic          zero_o
);

  always_comb begin
    pos_o  = '0;
    zero_o = (mag_i == '0);
    for (int i = 0; i < W; i++) begin
      if (mag_i[i]) pos_o = PW'(i);
    end
  end

endmodule

// File: rtl/fixed_log.sv
// Sequential ln(x) for sign-magnitude Q16.16: normalise, bit-serial log2 by squaring, scale by ln 2.
module fixed_log
  import fixed_point_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int ITERS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         err
);

  localparam int PW = $clog2(N - 1);
  localparam int CW = $clog2(ITERS + 1);

  log_state_e              state_q, state_d;
  logic [N-1:0]            x_q, x_d;
  logic [31:0]             m_q, m_d;
  logic [ITERS-1:0]        f_q, f_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [7:0]       k_q, k_d;
  logic [N-1:0]            y_q, y_d;
  logic                    err_q, err_d;

  logic [PW-1:0]           lod_pos;
  logic                    lod_zero;
  logic [31:0]             mag32;
  logic [31:0]             norm;
  logic [61:0]             sq;
  logic [31:0]             m_sq;

  // Log2 magnitude from exponent and fraction bits, then multiply by ln 2 (truncating).
  function automatic logic [N-1:0] ln2_scale(input logic signed [7:0] k,
                                             input logic [ITERS-1:0] f);
    logic [31:0] frac;
    logic [31:0] kmag;
    logic [31:0] l;
    logic [47:0] prod;
    logic        sgn;
    frac = 32'(f) << (Q - ITERS);
    if (k >= 0) begin
      kmag = 32'(unsigned'(k));
      l    = (kmag << Q) + frac;
      sgn  = 1'b0;
    end else begin
      kmag = 32'(unsigned'(-k));
      l    = (kmag << Q) - frac;
      sgn  = 1'b1;
    end
    prod = 48'(l) * 48'(LN2_Q16);
    if (l == '0) sgn = 1'b0;
    return {sgn, (N-1)'(prod >> Q)};
  endfunction

  fixed_lod #(.W(N - 1), .PW(PW)) u_lod (
    .mag_i  (x_q[N-2:0]),
    .pos_o  (lod_pos),
    .zero_o (lod_zero)
  );

  assign mag32 = 32'(x_q[N-2:0]);
  assign norm  = mag32 << (PW'(30) - lod_pos);
  assign sq    = 62'(m_q) * 62'(m_q);
  assign m_sq  = 32'(sq >> 30);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_d     = m_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        // -0 lands here too: its magnitude is zero.
        if (lod_zero || x_q[N-1]) begin
          err_d   = 1'b1;
          y_d     = ERR_VALUE[N-1:0];
          state_d = ST_DONE;
        end else begin
          err_d   = 1'b0;
          m_d     = norm;
          k_d     = $signed(8'(lod_pos)) - $signed(8'(Q));
          f_d     = '0;
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        // m is Q2.30 in [1,2); its square lies in [1,4), so bit 31 flags >= 2.0.
        if (m_sq[31]) begin
          m_d = m_sq >> 1;
          f_d = (f_q << 1) | ITERS'(1);
        end else begin
          m_d = m_sq;
          f_d = f_q << 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        y_d     = ln2_scale(k_q, f_q);
        err_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      m_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fixed_log.sv
// Directed-vector bench for fixed_log: exact power-of-two results, error cases, ln model sweep, handshake corners.
module tb_fixed_log;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        err;

  int total;
  int bad;

  fixed_log dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] xv;
    logic [31:0] yv;
    logic        ev;
    int          tol;
    bit          use_model;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic int sm_to_int(input logic [31:0] v);
    int m;
    m = int'({1'b0, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] int_to_sm(input int v);
    if (v < 0) return {1'b1, 31'(-v)};
    return {1'b0, 31'(v)};
  endfunction

  function automatic int ref_ln(input logic [31:0] xv);
    real r;
    r = $ln(real'(xv) / 65536.0) * 65536.0;
    return int'(r);
  endfunction

  // Caller is 1 time unit after a rising edge with the unit idle.
  task automatic do_op(input logic [31:0] xv, output logic [31:0] yv, output logic ev, output int lat);
    x = xv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    yv = y;
    ev = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string nm, input logic [31:0] xv, input logic [31:0] yv,
                              input logic ev, input int lat, input vec_t v);
    int d;
    int e;
    chk({nm, "_lat"}, lat == v.lat, 32'(lat), 32'(v.lat));
    chk({nm, "_err"}, ev == v.ev, {31'b0, ev}, {31'b0, v.ev});
    if (v.use_model) begin
      e = ref_ln(xv);
      d = sm_to_int(yv) - e;
      chk({nm, "_model"}, (d <= 4) && (d >= -4), yv, int_to_sm(e));
    end else if (v.tol > 0) begin
      d = sm_to_int(yv) - sm_to_int(v.yv);
      chk({nm, "_tol"}, (d <= v.tol) && (d >= -v.tol), yv, v.yv);
    end else begin
      chk({nm, "_y"}, yv === v.yv, yv, v.yv);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [31:0] yv;
    logic        ev;
    int          lat;
    int          cyc;
    bit          ok;
    bit          seen;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;

    vecs.push_back('{32'h0001_0000, 32'h0000_0000, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h0002_0000, 32'h0000_B172, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h0000_8000, 32'h8000_B172, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h0004_0000, 32'h0001_62E4, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h0000_4000, 32'h8001_62E4, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h0000_0001, 32'h800B_1720, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h4000_0000, 32'h0009_B43C, 1'b0, 0, 1'b0, 18});
    vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1});
    vecs.push_back('{32'h8001_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1});
    vecs.push_back('{32'h0002_B7E1, 32'h0001_0000, 1'b0, 4, 1'b0, 18});
    vecs.push_back('{32'h0003_0000, 32'h0, 1'b0, 0, 1'b1, 18});
    vecs.push_back('{32'h0000_1234, 32'h0, 1'b0, 0, 1'b1, 18});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0, 1'b0, 0, 1'b1, 18});
    vecs.push_back('{32'h0064_0000, 32'h0, 1'b0, 0, 1'b1, 18});
    vecs.push_back('{32'h0000_0003, 32'h0, 1'b0, 0, 1'b1, 18});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", in_ready && !out_valid && (y == 32'h0) && !err,
        {in_ready, out_valid, err, 29'b0} ^ y, 32'h8000_0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].xv, yv, ev, lat);
      check_result($sformatf("vec%0d", i), vecs[i].xv, yv, ev, lat, vecs[i]);
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] xr;
      xr = $urandom() >> $urandom_range(31, 1);
      if (xr == 32'h0) xr = 32'h1;
      v = '{xr, 32'h0, 1'b0, 0, 1'b1, 18};
      do_op(xr, yv, ev, lat);
      check_result($sformatf("sweep%0d", i), xr, yv, ev, lat, v);
    end

    // Back-pressure: result held in DONE, new requests ignored.
    x = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_reach_done", out_valid, 32'(cyc), 32'd18);
    x = 32'h0004_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ok = (y == 32'h0000_B172) && !err && !in_ready && out_valid;
      chk($sformatf("bp_hold%0d", i), ok, y, 32'h0000_B172);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", !out_valid && in_ready, {30'b0, out_valid, in_ready}, 32'h1);
    @(posedge clk); #1;
    chk("bp_idle", in_ready && !out_valid, {30'b0, out_valid, in_ready}, 32'h1);

    // out_ready already high before the result: exactly one valid cycle.
    out_ready = 1'b1;
    x = 32'h0004_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("early_rdy_y", out_valid && (y == 32'h0001_62E4), y, 32'h0001_62E4);
    @(posedge clk); #1;
    chk("early_rdy_pulse", !out_valid && in_ready, {30'b0, out_valid, in_ready}, 32'h1);
    out_ready = 1'b0;

    // Reset asserted mid-ITER.
    x = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("busy_mid_iter", !in_ready && !out_valid, {30'b0, out_valid, in_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_iter", in_ready && !out_valid && (y == 32'h0) && !err, y, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_valid_after_rst", !seen, {31'b0, seen}, 32'h0);
    v = '{32'h0000_8000, 32'h8000_B172, 1'b0, 0, 1'b0, 18};
    do_op(v.xv, yv, ev, lat);
    check_result("post_rst", v.xv, yv, ev, lat, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
